// File: rtl/adc_temp_averager_if.sv
// ADC response stream in, averaged temperature results out.
// The source/consumer side uses master; the averager uses slave.
interface adc_temp_averager_if #(
  parameter int DATA_W = 12
);
  logic              in_valid;
  logic [4:0]        in_channel;
  logic [DATA_W-1:0] in_data;
  logic              avg_valid;
  logic [DATA_W-1:0] avg_data;
  logic [DATA_W-1:0] temp_code;
  logic [DATA_W-1:0] min_code;
  logic [DATA_W-1:0] max_code;
  logic              stats_valid;
  logic              toggle;
  logic [7:0]        reject_count;

  modport master (
    output in_valid, in_channel, in_data,
    input  avg_valid, avg_data, temp_code, min_code, max_code,
    input  stats_valid, toggle, reject_count
  );

  modport slave (
    input  in_valid, in_channel, in_data,
    output avg_valid, avg_data, temp_code, min_code, max_code,
    output stats_valid, toggle, reject_count
  );
endinterface

// File: rtl/adc_temp_averager.sv
// Block-averages 2**LOG2_N samples of one ADC channel, forms an offset-corrected
// temperature code and tracks min/max of the results for the display path.
module adc_temp_averager #(
  parameter int DATA_W      = 12,
  parameter int LOG2_N      = 4,
  parameter int CHANNEL     = 17,
  parameter int TEMP_OFFSET = 3431
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          clear_stats,
  adc_temp_averager_if.slave bus
);
  localparam int ACC_W = DATA_W + LOG2_N;
  localparam int CNT_W = (LOG2_N > 0) ? LOG2_N : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((1 << LOG2_N) - 1);
  localparam logic [4:0]        CH_SEL   = 5'(CHANNEL);
  localparam logic [DATA_W-1:0] OFFSET   = DATA_W'(TEMP_OFFSET);

  typedef enum logic {ACCUM, EMIT} state_t;

  function automatic logic [DATA_W-1:0] sat_offset(input logic [DATA_W-1:0] avg);
    return (avg < OFFSET) ? '0 : avg - OFFSET;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              avg_valid_q, avg_valid_d;
  logic [DATA_W-1:0] avg_data_q, avg_data_d;
  logic [DATA_W-1:0] temp_code_q, temp_code_d;
  logic [DATA_W-1:0] min_code_q, min_code_d;
  logic [DATA_W-1:0] max_code_q, max_code_d;
  logic              stats_valid_q, stats_valid_d;
  logic              toggle_q, toggle_d;
  logic [7:0]        reject_count_q, reject_count_d;

  logic              accept;
  logic              mismatch;
  logic              last;
  logic [ACC_W-1:0]  sum;
  logic [DATA_W-1:0] avg_new;

  always_comb begin
    accept   = enable & bus.in_valid & (bus.in_channel == CH_SEL);
    mismatch = bus.in_valid & (bus.in_channel != CH_SEL);
    last     = accept & (cnt_q == CNT_LAST);
    sum      = acc_q + ACC_W'(bus.in_data);
    // N full-scale samples fit exactly in ACC_W, so the shift is a plain truncating divide
    avg_new  = DATA_W'(sum >> LOG2_N);

    state_d        = last ? EMIT : ACCUM;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    avg_valid_d    = last;
    avg_data_d     = avg_data_q;
    temp_code_d    = temp_code_q;
    min_code_d     = min_code_q;
    max_code_d     = max_code_q;
    stats_valid_d  = stats_valid_q;
    toggle_d       = toggle_q;
    reject_count_d = reject_count_q;

    if (!enable) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (last) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      acc_d = sum;
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (last) begin
      avg_data_d  = avg_new;
      temp_code_d = sat_offset(avg_new);
    end

    if (mismatch) reject_count_d = sat_inc8(reject_count_q);

    if (clear_stats) begin
      min_code_d    = '1;
      max_code_d    = '0;
      stats_valid_d = 1'b0;
    end

    // The EMIT cycle folds the just-published temp_code into the stats; a coincident
    // clear reseeds from it rather than losing the result.
    if (state_q == EMIT) begin
      toggle_d = ~toggle_q;
      if (clear_stats || !stats_valid_q) begin
        min_code_d = temp_code_q;
        max_code_d = temp_code_q;
      end else begin
        if (temp_code_q < min_code_q) min_code_d = temp_code_q;
        if (temp_code_q > max_code_q) max_code_d = temp_code_q;
      end
      stats_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ACCUM;
      acc_q          <= '0;
      cnt_q          <= '0;
      avg_valid_q    <= 1'b0;
      avg_data_q     <= '0;
      temp_code_q    <= '0;
      min_code_q     <= '1;
      max_code_q     <= '0;
      stats_valid_q  <= 1'b0;
      toggle_q       <= 1'b0;
      reject_count_q <= '0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      avg_valid_q    <= avg_valid_d;
      avg_data_q     <= avg_data_d;
      temp_code_q    <= temp_code_d;
      min_code_q     <= min_code_d;
      max_code_q     <= max_code_d;
      stats_valid_q  <= stats_valid_d;
      toggle_q       <= toggle_d;
      reject_count_q <= reject_count_d;
    end
  end

  assign bus.avg_valid    = avg_valid_q;
  assign bus.avg_data     = avg_data_q;
  assign bus.temp_code    = temp_code_q;
  assign bus.min_code     = min_code_q;
  assign bus.max_code     = max_code_q;
  assign bus.stats_valid  = stats_valid_q;
  assign bus.toggle       = toggle_q;
  assign bus.reject_count = reject_count_q;
endmodule

// File: tb/tb_adc_temp_averager.sv
// Bench for adc_temp_averager: directed scenarios plus randomized traffic against a
// window-queue reference model.
module tb_adc_temp_averager;
  localparam int DATA_W = 12;
  localparam int LOG2_N = 4;
  localparam int N      = 16;
  localparam int CH     = 17;
  localparam int OFF    = 3431;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic clear_stats = 1'b0;

  adc_temp_averager_if #(.DATA_W(DATA_W)) bus ();

  adc_temp_averager #(
    .DATA_W(DATA_W), .LOG2_N(LOG2_N), .CHANNEL(CH), .TEMP_OFFSET(OFF)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .clear_stats(clear_stats), .bus(bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobes = 0;
  int strobe_cyc[$];

  always @(posedge clock) cyc++;
  always @(negedge clock) if (bus.avg_valid === 1'b1) begin
    strobes++;
    strobe_cyc.push_back(cyc);
  end

  // reference model: accepted samples of the current window and result history
  int m_win[$];
  int m_rej, m_avg, m_temp, m_min, m_max, m_results;
  bit m_sv, m_tog;

  task automatic model_reset();
    m_win.delete();
    m_rej = 0; m_avg = 0; m_temp = 0; m_min = 4095; m_max = 0; m_results = 0;
    m_sv = 0; m_tog = 0;
  endtask

  // one clock with the given stream inputs; model follows at the same edge
  task automatic step(input bit v, input int ch, input int d);
    int sum;
    bus.in_valid = v;
    bus.in_channel = 5'(ch);
    bus.in_data = DATA_W'(d);
    @(posedge clock);
    #1;
    if (v && ch != CH && m_rej < 255) m_rej++;
    if (!enable) m_win.delete();
    else if (v && ch == CH) begin
      m_win.push_back(d);
      if (m_win.size() == N) begin
        sum = 0;
        foreach (m_win[i]) sum += m_win[i];
        m_avg = sum / N;
        m_temp = (m_avg < OFF) ? 0 : m_avg - OFF;
        m_results++;
        if (!m_sv) begin m_min = m_temp; m_max = m_temp; m_sv = 1; end
        else begin
          if (m_temp < m_min) m_min = m_temp;
          if (m_temp > m_max) m_max = m_temp;
        end
        m_tog = !m_tog;
        m_win.delete();
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    enable = 1'b1;
    do_reset();
    checks++; if (bus.avg_valid !== 1'b0) begin errors++; $display("FAIL reset_avg_valid: got %0d expected 0", bus.avg_valid); end
    checks++; if (bus.avg_data !== 12'd0) begin errors++; $display("FAIL reset_avg_data: got %0d expected 0", bus.avg_data); end
    checks++; if (bus.temp_code !== 12'd0) begin errors++; $display("FAIL reset_temp_code: got %0d expected 0", bus.temp_code); end
    checks++; if (bus.min_code !== 12'hFFF) begin errors++; $display("FAIL reset_min: got %0d expected 4095", bus.min_code); end
    checks++; if (bus.max_code !== 12'd0) begin errors++; $display("FAIL reset_max: got %0d expected 0", bus.max_code); end
    checks++; if (bus.stats_valid !== 1'b0 || bus.toggle !== 1'b0) begin errors++; $display("FAIL reset_flags: got sv=%0d tog=%0d expected 0/0", bus.stats_valid, bus.toggle); end
    checks++; if (bus.reject_count !== 8'd0) begin errors++; $display("FAIL reset_reject: got %0d expected 0", bus.reject_count); end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 15; i++) step(1, CH, 3500);
    checks++; if (bus.avg_valid !== 1'b0) begin errors++; $display("FAIL basic_early_strobe: got %0d expected 0", bus.avg_valid); end
    step(1, CH, 3500);
    checks++; if (bus.avg_valid !== 1'b1) begin errors++; $display("FAIL basic_strobe: got %0d expected 1", bus.avg_valid); end
    checks++; if (bus.avg_data !== 12'd3500) begin errors++; $display("FAIL basic_avg: got %0d expected 3500", bus.avg_data); end
    checks++; if (bus.temp_code !== 12'd69) begin errors++; $display("FAIL basic_temp: got %0d expected 69", bus.temp_code); end
    idle(1);
    checks++; if (bus.avg_valid !== 1'b0) begin errors++; $display("FAIL basic_strobe_width: got %0d expected 0", bus.avg_valid); end
    checks++; if (bus.min_code !== 12'd69 || bus.max_code !== 12'd69) begin errors++; $display("FAIL basic_minmax: got %0d/%0d expected 69/69", bus.min_code, bus.max_code); end
    checks++; if (bus.stats_valid !== 1'b1 || bus.toggle !== 1'b1) begin errors++; $display("FAIL basic_flags: got sv=%0d tog=%0d expected 1/1", bus.stats_valid, bus.toggle); end
  endtask

  task automatic test_truncation();
    for (int i = 0; i < 16; i++) step(1, CH, (i < 8) ? 3440 : 3441);
    checks++; if (bus.avg_data !== 12'd3440 || bus.temp_code !== 12'd9) begin errors++; $display("FAIL truncation: got avg=%0d temp=%0d expected 3440/9", bus.avg_data, bus.temp_code); end
    idle(1);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 16; i++) step(1, CH, 3000);
    checks++; if (bus.avg_data !== 12'd3000 || bus.temp_code !== 12'd0) begin errors++; $display("FAIL sat_low: got avg=%0d temp=%0d expected 3000/0", bus.avg_data, bus.temp_code); end
    idle(1);
    for (int i = 0; i < 16; i++) step(1, CH, 4095);
    checks++; if (bus.avg_data !== 12'd4095 || bus.temp_code !== 12'd664) begin errors++; $display("FAIL full_scale: got avg=%0d temp=%0d expected 4095/664", bus.avg_data, bus.temp_code); end
    idle(1);
    checks++; if (bus.min_code !== 12'd0 || bus.max_code !== 12'd664) begin errors++; $display("FAIL sat_minmax: got %0d/%0d expected 0/664", bus.min_code, bus.max_code); end
  endtask

  task automatic test_reject();
    int nrej = 0;
    int k = 0;
    int i = 0;
    int s0;
    do_reset();
    s0 = strobes;
    while (nrej < 300 || k < 16) begin
      if (k < 16 && (i % 19 == 3 || nrej >= 300)) begin step(1, CH, 3600); k++; end
      else begin step(1, 5, int'($urandom_range(0, 4095))); nrej++; end
      i++;
    end
    idle(2);
    checks++; if (strobes - s0 != 1) begin errors++; $display("FAIL reject_strobes: got %0d expected 1", strobes - s0); end
    checks++; if (bus.avg_data !== 12'd3600) begin errors++; $display("FAIL reject_avg: got %0d expected 3600", bus.avg_data); end
    checks++; if (bus.reject_count !== 8'd255) begin errors++; $display("FAIL reject_count: got %0d expected 255", bus.reject_count); end
  endtask

  task automatic test_minmax_clear();
    do_reset();
    for (int i = 0; i < 16; i++) step(1, CH, 3500);
    for (int i = 0; i < 16; i++) step(1, CH, 3600);
    for (int i = 0; i < 16; i++) step(1, CH, 3450);
    idle(1);
    checks++; if (bus.min_code !== 12'd19 || bus.max_code !== 12'd169) begin errors++; $display("FAIL minmax: got %0d/%0d expected 19/169", bus.min_code, bus.max_code); end
    for (int i = 0; i < 16; i++) step(1, CH, 3480);
    clear_stats = 1'b1;
    idle(1);
    clear_stats = 1'b0;
    checks++; if (bus.min_code !== 12'd49 || bus.max_code !== 12'd49 || bus.stats_valid !== 1'b1) begin errors++; $display("FAIL clear_coincident: got %0d/%0d sv=%0d expected 49/49 sv=1", bus.min_code, bus.max_code, bus.stats_valid); end
    clear_stats = 1'b1;
    idle(1);
    clear_stats = 1'b0;
    checks++; if (bus.min_code !== 12'hFFF || bus.max_code !== 12'd0 || bus.stats_valid !== 1'b0) begin errors++; $display("FAIL clear_alone: got %0d/%0d sv=%0d expected 4095/0 sv=0", bus.min_code, bus.max_code, bus.stats_valid); end
    m_min = 4095; m_max = 0; m_sv = 0;
  endtask

  task automatic test_reset_midwindow();
    int s0;
    for (int i = 0; i < 10; i++) step(1, CH, 4000);
    do_reset();
    s0 = strobes;
    for (int i = 0; i < 15; i++) step(1, CH, 3500);
    checks++; if (strobes != s0 || bus.avg_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_early: got %0d strobes expected 0", strobes - s0); end
    step(1, CH, 3500);
    checks++; if (bus.avg_valid !== 1'b1 || bus.avg_data !== 12'd3500) begin errors++; $display("FAIL reset_mid_result: got v=%0d avg=%0d expected 1/3500", bus.avg_valid, bus.avg_data); end
    idle(1);
  endtask

  task automatic test_enable_abort();
    int s0;
    for (int i = 0; i < 10; i++) step(1, CH, 4000);
    enable = 1'b0;
    step(1, CH, 4000);
    step(1, CH, 4000);
    enable = 1'b1;
    s0 = strobes;
    for (int i = 0; i < 15; i++) step(1, CH, 3500);
    checks++; if (strobes != s0 || bus.avg_valid !== 1'b0) begin errors++; $display("FAIL enable_early: got %0d strobes expected 0", strobes - s0); end
    step(1, CH, 3500);
    checks++; if (bus.avg_valid !== 1'b1 || bus.avg_data !== 12'd3500) begin errors++; $display("FAIL enable_result: got v=%0d avg=%0d expected 1/3500", bus.avg_valid, bus.avg_data); end
    idle(1);
  endtask

  task automatic test_back_to_back();
    int base;
    int r0;
    base = strobe_cyc.size();
    for (int i = 0; i < 48; i++) begin
      r0 = m_results;
      step(1, CH, int'($urandom_range(3300, 4095)));
      checks++; if (bus.avg_valid !== (m_results != r0)) begin errors++; $display("FAIL b2b_strobe[%0d]: got %0d expected %0d", i, bus.avg_valid, m_results != r0); end
      if (m_results != r0) begin
        checks++; if (bus.avg_data !== DATA_W'(m_avg)) begin errors++; $display("FAIL b2b_avg[%0d]: got %0d expected %0d", i, bus.avg_data, m_avg); end
      end
    end
    idle(2);
    checks++;
    if (strobe_cyc.size() - base != 3) begin
      errors++; $display("FAIL b2b_count: got %0d expected 3", strobe_cyc.size() - base);
    end else if (strobe_cyc[base+1] - strobe_cyc[base] != 16 || strobe_cyc[base+2] - strobe_cyc[base+1] != 16) begin
      errors++; $display("FAIL b2b_spacing: got %0d,%0d expected 16,16", strobe_cyc[base+1] - strobe_cyc[base], strobe_cyc[base+2] - strobe_cyc[base+1]);
    end
  endtask

  task automatic test_random();
    int r0;
    int ch;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      enable = ($urandom_range(0, 59) != 0);
      ch = ($urandom_range(0, 3) != 0) ? CH : int'($urandom_range(0, 31));
      r0 = m_results;
      step($urandom_range(0, 4) != 0, ch, int'($urandom_range(3200, 4095)));
      checks++; if (bus.avg_valid !== (m_results != r0)) begin errors++; $display("FAIL rand_strobe[%0d]: got %0d expected %0d", i, bus.avg_valid, m_results != r0); end
      if (m_results != r0) begin
        checks++; if (bus.avg_data !== DATA_W'(m_avg) || bus.temp_code !== DATA_W'(m_temp)) begin errors++; $display("FAIL rand_result[%0d]: got %0d/%0d expected %0d/%0d", i, bus.avg_data, bus.temp_code, m_avg, m_temp); end
      end
    end
    enable = 1'b1;
    idle(2);
    checks++; if (bus.min_code !== DATA_W'(m_min) || bus.max_code !== DATA_W'(m_max)) begin errors++; $display("FAIL rand_minmax: got %0d/%0d expected %0d/%0d", bus.min_code, bus.max_code, m_min, m_max); end
    checks++; if (bus.stats_valid !== m_sv || bus.toggle !== m_tog) begin errors++; $display("FAIL rand_flags: got sv=%0d tog=%0d expected %0d/%0d", bus.stats_valid, bus.toggle, m_sv, m_tog); end
    checks++; if (bus.reject_count !== 8'(m_rej)) begin errors++; $display("FAIL rand_reject: got %0d expected %0d", bus.reject_count, m_rej); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_channel = '0;
    bus.in_data = '0;
    model_reset();
    test_reset();
    test_basic();
    test_truncation();
    test_saturation();
    test_reject();
    test_minmax_clear();
    test_reset_midwindow();
    test_enable_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
